// File: rtl/alu_pkg.sv
// Shared select codes, FSM encoding and error result constants for the ALU dispatch block.
package alu_pkg;
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_MUL  = 4'b0001;
   localparam logic [3:0] OP_DIV  = 4'b0010;
   localparam logic [3:0] OP_NAND = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;

   localparam logic [15:0] DIVZERO_DATA = 16'hFFFF;
   localparam logic [15:0] ILLEGAL_DATA = 16'h0000;

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// Combinational screen of a request: hold latency, illegal select, divide by zero.
module alu_op_decode
   import alu_pkg::*;
#(
   parameter int ADD_LAT = 1,
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 4
) (
   input  logic [3:0]  op,
   input  logic [15:0] b,
   output logic [3:0]  lat,
   output logic        illegal,
   output logic        div_zero
);
   always_comb begin
      lat = 4'(ADD_LAT);
      if (op == OP_MUL)      lat = 4'(MUL_LAT);
      else if (op == OP_DIV) lat = 4'(DIV_LAT);
   end

   assign illegal  = (op > OP_XOR);
   assign div_zero = (op == OP_DIV) && (b == 16'h0000);
endmodule

// File: rtl/alu_dispatch.sv
// Requester side of the 16-bit ALU interface: issue, per-op hold, capture, respond.
// Define ALU_DISPATCH_PIPE_EN to accept a new request on the response handshake edge.
module alu_dispatch
   import alu_pkg::*;
#(
   parameter int TAG_W   = 4,
   parameter int ADD_LAT = 1,
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [15:0]      req_a,
   input  logic [15:0]      req_b,
   input  logic             req_cin,
   input  logic [3:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic [15:0]      alu_a,
   output logic [15:0]      alu_b,
   output logic             alu_cin,
   output logic [3:0]       alu_sel,
   input  logic [15:0]      alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err
);
   state_t     state;
   logic [3:0] cnt;
   logic [3:0] dec_lat;
   logic       dec_illegal;
   logic       dec_div_zero;
   logic       accept;

   alu_op_decode #(
      .ADD_LAT(ADD_LAT),
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT)
   ) u_dec (
      .op      (req_op),
      .b       (req_b),
      .lat     (dec_lat),
      .illegal (dec_illegal),
      .div_zero(dec_div_zero)
   );

`ifdef ALU_DISPATCH_PIPE_EN
   assign req_ready = !rst && ((state == IDLE) || ((state == HOLD) && rsp_ready));
`else
   assign req_ready = !rst && (state == IDLE);
`endif

   assign accept = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         alu_a     <= 16'h0000;
         alu_b     <= 16'h0000;
         alu_cin   <= 1'b0;
         alu_sel   <= OP_ADD;
         rsp_valid <= 1'b0;
         rsp_data  <= 16'h0000;
         rsp_tag   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rsp_data  <= alu_result;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: ;
         endcase

         // Accept last so a pipelined accept in HOLD overrides the return to IDLE.
         if (accept) begin
            rsp_tag <= req_tag;
            if (dec_illegal || dec_div_zero) begin
               // Screened ops never reach the ALU; alu_* keep the previous op.
               rsp_data  <= dec_illegal ? ILLEGAL_DATA : DIVZERO_DATA;
               rsp_err   <= 1'b1;
               rsp_valid <= 1'b1;
               state     <= HOLD;
            end else begin
               alu_a   <= req_a;
               alu_b   <= req_b;
               alu_cin <= req_cin;
               alu_sel <= req_op;
               cnt     <= dec_lat - 4'd1;
               state   <= EXEC;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: latency, data, tag, error, backpressure and reset.
module tb_alu_dispatch;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_a = '0, req_b = '0;
   logic        req_cin = 1'b0;
   logic [3:0]  req_op = '0;
   logic [3:0]  req_tag = '0;
   logic [15:0] alu_a, alu_b;
   logic        alu_cin;
   logic [3:0]  alu_sel;
   logic [15:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic        rsp_err;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  tag;
      logic        err;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_dispatch dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op), .req_tag(req_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
   );

   // Behavioural combinational ALU sitting on the far side of the interface.
   function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic [3:0] op);
      logic signed [15:0] sa, sb;
      sa = a;
      sb = b;
      case (op)
         OP_ADD:  return a + b + {15'd0, cin};
         OP_MUL:  return a * b;
         OP_DIV:  return (b == 16'h0) ? 16'h0 : 16'(sa / sb);
         OP_NAND: return ~(a & b);
         OP_NOR:  return ~(a | b);
         OP_NOT:  return ~a;
         OP_XOR:  return a ^ b;
         default: return 16'h0;
      endcase
   endfunction

   always_comb alu_result = alu_f(alu_a, alu_b, alu_cin, alu_sel);

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [3:0] op, input logic [3:0] tag, input int stall);
      exp_t e, got;
      int n;
      logic [15:0] prev_b;
      e.err  = (op > 4'd6) || (op == OP_DIV && b == 16'h0);
      e.data = (op > 4'd6) ? 16'h0000 : e.err ? 16'hFFFF : alu_f(a, b, cin, op);
      e.tag  = tag;
      e.lat  = e.err ? 0 : (op == OP_MUL) ? 2 : (op == OP_DIV) ? 4 : 1;
      @(negedge clk);
      req_a = a; req_b = b; req_cin = cin; req_op = op; req_tag = tag; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!req_ready) begin
         errors++; $display("FAIL accept_timeout op=%h: req_ready got 0 want 1", op);
         req_valid = 1'b0; return;
      end
      prev_b = alu_b;
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      got = exp_q.pop_front();
      checks++;
      if (!rsp_valid) begin
         errors++; $display("FAIL rsp_timeout op=%h: rsp_valid never rose", op); return;
      end
      checks++;
      if (n !== got.lat) begin errors++; $display("FAIL latency op=%h: got %0d want %0d", op, n, got.lat); end
      if (got.err) begin
         checks++;
         if (alu_b !== prev_b) begin errors++; $display("FAIL alu_b_kept op=%h: got %h want %h", op, alu_b, prev_b); end
      end
      for (int i = 0; i < stall; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== got.data || rsp_err !== got.err || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                     i, rsp_valid, rsp_data, rsp_err, req_ready, got.data, got.err);
         end
         @(negedge clk);
      end
      checks++;
      if (rsp_data !== got.data) begin errors++; $display("FAIL rsp_data op=%h: got %h want %h", op, rsp_data, got.data); end
      checks++;
      if (rsp_tag !== got.tag) begin errors++; $display("FAIL rsp_tag op=%h: got %h want %h", op, rsp_tag, got.tag); end
      checks++;
      if (rsp_err !== got.err) begin errors++; $display("FAIL rsp_err op=%h: got %b want %b", op, rsp_err, got.err); end
      rsp_ready = 1'b1;
      #1;
      checks++;
`ifdef ALU_DISPATCH_PIPE_EN
      if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_ready: got %b want 1", req_ready); end
`else
      if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", req_ready); end
`endif
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL after_handshake: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_tag !== 4'h0 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL reset_rsp: got rdy=%b v=%b d=%h t=%h e=%b want all 0",
                            req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err);
      end
      checks++;
      if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_cin !== 1'b0 || alu_sel !== 4'h0) begin
         errors++; $display("FAIL reset_alu: got a=%h b=%h c=%b s=%h want 0", alu_a, alu_b, alu_cin, alu_sel);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
   endtask

   task automatic test_ops();
      run_op(16'd5, 16'd7, 1'b1, OP_ADD, 4'h3, 0);
      run_op(16'hFFFD, 16'd4, 1'b0, OP_MUL, 4'h5, 0);
      run_op(16'd100, 16'd7, 1'b0, OP_DIV, 4'h9, 0);
      run_op(16'h00F0, 16'h0FF0, 1'b0, OP_NAND, 4'h1, 0);
      run_op(16'h00F0, 16'h0F00, 1'b0, OP_NOR, 4'h2, 0);
      run_op(16'h1234, 16'h0, 1'b0, OP_NOT, 4'h4, 0);
      run_op(16'hA5A5, 16'h0FF0, 1'b0, OP_XOR, 4'h6, 0);
   endtask

   task automatic test_errors();
      run_op(16'd100, 16'd0, 1'b0, OP_DIV, 4'hA, 0);
      run_op(16'd1, 16'd2, 1'b0, 4'b1000, 4'hB, 3);
      run_op(16'd1, 16'd2, 1'b0, 4'b0111, 4'hC, 1);
      run_op(16'd9, 16'd9, 1'b1, 4'b1111, 4'hD, 0);
   endtask

   task automatic test_back_to_back();
      logic [15:0] a, b;
      logic [3:0]  op;
      for (int i = 0; i < 12; i++) begin
         a  = 16'($urandom);
         b  = 16'($urandom_range(0, 40));
         op = 4'($urandom_range(0, 9));
         run_op(a, b, 1'($urandom), op, 4'(i), int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      @(negedge clk);
      req_a = 16'd100; req_b = 16'd7; req_op = OP_DIV; req_tag = 4'hE; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_tag !== 4'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0 ||
          alu_a !== 16'h0 || alu_b !== 16'h0 || alu_sel !== 4'h0) begin
         errors++; $display("FAIL midop_reset: got v=%b d=%h t=%h e=%b rdy=%b a=%h b=%h s=%h want all 0",
                            rsp_valid, rsp_data, rsp_tag, rsp_err, req_ready, alu_a, alu_b, alu_sel);
      end
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL dropped_op: rsp_valid seen %0d cycles want 0", seen); end
      run_op(16'd20, 16'd22, 1'b0, OP_ADD, 4'h7, 0);
   endtask

   initial begin
      test_reset();
      test_ops();
      test_errors();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
